// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared requester ids, FSM states and default widths for the memory port arbiter
package mem_arb_pkg;
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;
    typedef enum logic [1:0] {ID_IF = 2'd0, ID_DP = 2'd1, ID_DMA = 2'd2} req_id_e;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/arb_age_counter.sv
// arb_age_counter: saturating DMA starvation counter; limit_hit promotes DMA to top priority
module arb_age_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);
    logic [W-1:0] cnt;
    // count lost arbitrations, clear on grant, stop at the limit
    always_ff @(posedge clk)
        if (!rst_n || clr) cnt <= '0;
        else if (inc && cnt < LIM) cnt <= cnt + 1'b1;
    assign limit_hit = cnt >= LIM;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF/DP/DMA onto one memory port; MEM_PORT_ARB_PERF_EN adds perf counters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_AW,
    parameter int DATA_WIDTH   = DEF_DW,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_done,
    input  logic                  dp_req,
    input  logic                  dp_we,
    input  logic [ADDR_WIDTH-1:0] dp_addr,
    input  logic [DATA_WIDTH-1:0] dp_wdata,
    output logic                  dp_gnt,
    output logic                  dp_done,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [15:0]           if_cnt,
    output logic [15:0]           dp_cnt,
    output logic [15:0]           dma_cnt,
    output logic [15:0]           stall_cnt
`endif
);
    localparam int TO_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_e state, state_nxt;
    req_id_e owner;
    logic cmd_we, err_q, age_hi, any_gnt, timeout;
    logic [TO_W-1:0] tcnt;
    arb_age_counter #(.LIMIT(STARVE_LIMIT)) u_age (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (state == IDLE && dma_req && !dma_gnt),
        .clr      (dma_gnt),
        .limit_hit(age_hi)
    );
    assign any_gnt  = if_gnt || dp_gnt || dma_gnt;
    assign timeout  = TIMEOUT != 0 && tcnt == TO_LAST;
    assign mem_req  = state == BUSY;
    assign mem_we   = mem_req && cmd_we;
    assign if_done  = state == RESP && owner == ID_IF;
    assign dp_done  = state == RESP && owner == ID_DP;
    assign dma_done = state == RESP && owner == ID_DMA;
    assign err      = state == RESP && err_q;
    // state register
    always_ff @(posedge clk)
        state <= rst_n ? state_nxt : IDLE;
    // arbitration in IDLE (aged DMA jumps the queue) and transaction sequencing
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        dp_gnt    = 1'b0;
        dma_gnt   = 1'b0;
        case (state)
            IDLE: begin
                dma_gnt   = dma_req && (age_hi || (!dp_req && !if_req));
                dp_gnt    = dp_req && !(age_hi && dma_req);
                if_gnt    = if_req && !dp_req && !(age_hi && dma_req);
                state_nxt = (dma_gnt || dp_gnt || if_gnt) ? BUSY : IDLE;
            end
            BUSY:    state_nxt = (mem_ready || timeout) ? RESP : BUSY;
            default: state_nxt = IDLE;
        endcase
    end
    // latch the winning command, capture read data, flag timeouts
    always_ff @(posedge clk)
        if (!rst_n) begin
            owner     <= ID_IF;
            cmd_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            err_q     <= 1'b0;
            tcnt      <= '0;
        end else if (any_gnt) begin
            owner     <= dma_gnt ? ID_DMA : dp_gnt ? ID_DP : ID_IF;
            cmd_we    <= dma_gnt ? dma_we : dp_gnt && dp_we;
            mem_addr  <= dma_gnt ? dma_addr : dp_gnt ? dp_addr : if_addr;
            mem_wdata <= dma_gnt ? dma_wdata : dp_gnt ? dp_wdata : '0;
            err_q     <= 1'b0;
            tcnt      <= '0;
        end else if (state == BUSY) begin
            tcnt <= tcnt + 1'b1;
            if (mem_ready && !cmd_we) rdata <= mem_rdata;
            if (!mem_ready && timeout) err_q <= 1'b1;
        end
`ifdef MEM_PORT_ARB_PERF_EN
    // grant and stall statistics, free-running with wrap
    always_ff @(posedge clk)
        if (!rst_n) begin
            if_cnt    <= '0;
            dp_cnt    <= '0;
            dma_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if_cnt    <= if_cnt + 16'(if_gnt);
            dp_cnt    <= dp_cnt + 16'(dp_gnt);
            dma_cnt   <= dma_cnt + 16'(dma_gnt);
            stall_cnt <= stall_cnt + 16'((if_req || dp_req || dma_req) && !any_gnt);
        end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for the memory port arbiter
module tb_mem_port_arbiter;
    logic clk = 0, rst_n = 0;
    logic if_req = 0, dp_req = 0, dp_we = 0, dma_req = 0, dma_we = 0, mem_ready = 0;
    logic [15:0] if_addr = 0, dp_addr = 0, dp_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
    logic if_gnt, if_done, dp_gnt, dp_done, dma_gnt, dma_done, err, mem_req, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [15:0] if_cnt, dp_cnt, dma_cnt, stall_cnt;
`endif
    int n_chk = 0, n_err = 0;

    mem_port_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_gnt(dp_gnt), .dp_done(dp_done),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done),
        .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef MEM_PORT_ARB_PERF_EN
        , .if_cnt(if_cnt), .dp_cnt(dp_cnt), .dma_cnt(dma_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset, then idle with no requests
        repeat (3) step();
        rst_n = 1;
        repeat (5) step();
        #1;
        check("rst_gnt", {if_gnt, dp_gnt, dma_gnt}, 0);
        check("rst_done", {if_done, dp_done, dma_done, err}, 0);
        check("rst_mem", {mem_req, mem_we}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_state", 32'(dut.state), 0);

        // DP beats IF; DP read of 0x0040
        step();
        if_req = 1; if_addr = 16'h0100; dp_req = 1; dp_we = 0; dp_addr = 16'h0040;
        #1;
        check("prio_dp_gnt", {if_gnt, dp_gnt, dma_gnt}, 3'b010);
        step(); dp_req = 0; #1;
        check("rd_busy", {mem_req, mem_we, if_gnt}, 3'b100);
        check("rd_addr", mem_addr, 16'h0040);
        step(); #1;
        check("rd_busy2", mem_req, 1);
        step(); mem_ready = 1; mem_rdata = 16'hBEEF;
        step(); mem_ready = 0; #1;
        check("rd_done", {dp_done, if_done, err, mem_req, if_gnt}, 5'b10000);
        check("rd_rdata", rdata, 16'hBEEF);
        step(); #1;
        check("if_after_dp", {if_gnt, dp_done}, 2'b10);
        step(); if_req = 0; mem_ready = 1; mem_rdata = 16'h1111;
        step(); mem_ready = 0; #1;
        check("if_done", {if_done, dp_done}, 2'b10);
        check("if_rdata", rdata, 16'h1111);

        // DMA starvation: DP re-requests every slot, DMA wins the 9th arbitration
        step();
        dp_req = 1; dp_addr = 16'h0010; dma_req = 1; dma_we = 1; dma_addr = 16'h2000;
        dma_wdata = 16'h5555; mem_ready = 1; mem_rdata = 16'h0A0A;
        for (int i = 1; i <= 9; i++) begin
            #1;
            check($sformatf("age_arb%0d", i), {dp_gnt, dma_gnt}, i < 9 ? 2'b10 : 2'b01);
            if (i < 9) begin step(); step(); step(); end
        end
        step(); dma_req = 0; #1;
        check("dma_wr", {mem_req, mem_we}, 2'b11);
        check("dma_addr", mem_addr, 16'h2000);
        check("dma_wdata", mem_wdata, 16'h5555);
        check("age_clr", 32'(dut.u_age.cnt), 0);
        step(); #1;
        check("dma_done", {dma_done, dp_done}, 2'b10);
        check("dma_rdata", rdata, 16'h0A0A);
        step(); #1;
        check("dp_after_dma", dp_gnt, 1);
        step(); dp_req = 0;
        step(); step(); mem_ready = 0;

        // DP write 0x1234 to 0x00FE, rdata unchanged
        dp_req = 1; dp_we = 1; dp_addr = 16'h00FE; dp_wdata = 16'h1234; #1;
        check("wr_gnt", dp_gnt, 1);
        step(); dp_req = 0; #1;
        check("wr_cmd", {mem_req, mem_we}, 2'b11);
        check("wr_addr", mem_addr, 16'h00FE);
        check("wr_wdata", mem_wdata, 16'h1234);
        step(); #1;
        check("wr_hold", {mem_req, mem_we}, 2'b11);
        mem_ready = 1; mem_rdata = 16'hDEAD;
        step(); mem_ready = 0; #1;
        check("wr_done", {dp_done, mem_we, err}, 3'b100);
        check("wr_rdata", rdata, 16'h0A0A);

        // timeout after 4 BUSY cycles, then a normal request
        step(); dp_we = 0; if_req = 1; if_addr = 16'h0300; #1;
        check("to_gnt", if_gnt, 1);
        for (int j = 1; j <= 4; j++) begin
            step(); if_req = 0; #1;
            check($sformatf("to_busy%0d", j), mem_req, 1);
        end
        step(); #1;
        check("to_done", {if_done, err, mem_req}, 3'b110);
        check("to_rdata", rdata, 16'h0A0A);
        step(); dp_req = 1; dp_addr = 16'h0050; #1;
        check("to_next_gnt", dp_gnt, 1);
        step(); dp_req = 0; mem_ready = 1; mem_rdata = 16'h7777;
        step(); mem_ready = 0; #1;
        check("to_next_done", {dp_done, err}, 2'b10);
        check("to_next_rdata", rdata, 16'h7777);

        // ready on the expiry cycle wins over the timeout
        step(); if_req = 1; #1;
        check("rt_gnt", if_gnt, 1);
        step(); if_req = 0;
        step(); step();
        step(); mem_ready = 1; mem_rdata = 16'h4242;
        step(); mem_ready = 0; #1;
        check("rt_done", {if_done, err}, 2'b10);
        check("rt_rdata", rdata, 16'h4242);

        // reset while BUSY abandons the access without a done
        step(); if_req = 1; #1;
        check("rb_gnt", if_gnt, 1);
        step(); if_req = 0; #1;
        check("rb_busy", mem_req, 1);
        rst_n = 0;
        step(); #1;
        check("rb_mem_req", mem_req, 0);
        check("rb_state", 32'(dut.state), 0);
        rst_n = 1;
        step(); #1;
        check("rb_no_done", {if_done, dp_done, dma_done, err}, 0);
        check("rb_rdata", rdata, 0);

`ifdef MEM_PORT_ARB_PERF_EN
        // three IF grants with the request held through each transaction
        step(); if_req = 1; mem_ready = 1;
        for (int g = 0; g < 3; g++) begin
            #1;
            check($sformatf("perf_gnt%0d", g), if_gnt, 1);
            step(); if (g == 2) if_req = 0;
            step(); step();
        end
        #1;
        check("perf_if_cnt", if_cnt, 3);
        check("perf_stall", stall_cnt, 4);
        check("perf_other", {dp_cnt, dma_cnt}, 0);
        mem_ready = 0;
`endif

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
